fp_addsub_sign_stage: RTL and testbench

Pipelined sign-resolution and operand-ordering stage for the FPU adder/subtractor. It sits between the exponent compare/align stage and the mantissa add/sub stage. It resolves the result sign and the effective operation, and optionally swaps mantissas so the larger one is always on port A. It applies the IEEE-754 exact-cancellation zero-sign rule from the RISC-V rounding mode. A valid/ready handshake with a 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/fp_addsub_sign_stage.sv | 149 ++++++++++++++
 tb/tb_fp_addsub_sign_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_sign_stage.sv
// Purpose   : FPU add/sub sign-resolution and operand-ordering stage. Sits between
//             exponent align and mantissa add/sub.
// Latency   : 1 cycle from input accept to out_valid when the output register is free.
// Backpress.: main + skid register; in_ready is registered (!skid_valid), so there is
//             no combinational path from out_ready.
//
// Ports:
//   clk, rst_n (sync, active low), flush (sync pipeline clear)
//   in_valid/in_ready    : input handshake
//   s_a, s_b             : operand signs
//   ma_in, mb_in         : aligned mantissas (MANT_W incl. hidden/guard/round/sticky)
//   comp                 : 1 = |A| >= |B|
//   mag_eq               : 1 = |A| == |B|
//   a_s                  : 0 = add, 1 = sub
//   rm                   : RISC-V frm rounding mode
//   out_valid/out_ready  : output handshake
//   s_o                  : result sign
//   ma_o, mb_o           : larger/smaller mantissa (A/B when SWAP_EN=0)
//   eff_sub              : effective mantissa subtraction
//   zero_res             : exact cancellation, result is a signed zero
module fp_addsub_sign_stage #(
  parameter int MANT_W  = 28,
  parameter bit SWAP_EN = 1'b1,
  parameter int RM_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              s_a,
  input  logic              s_b,
  input  logic [MANT_W-1:0] ma_in,
  input  logic [MANT_W-1:0] mb_in,
  input  logic              comp,
  input  logic              mag_eq,
  input  logic              a_s,
  input  logic [RM_W-1:0]   rm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s_o,
  output logic [MANT_W-1:0] ma_o,
  output logic [MANT_W-1:0] mb_o,
  output logic              eff_sub,
  output logic              zero_res
);

  // Payload layout: {s_o, eff_sub, zero_res, ma, mb}
  localparam int PW = 3 + 2 * MANT_W;
  localparam logic [RM_W-1:0] RM_RDN = RM_W'(2);

  // ---------------------------------------------------------------------------
  // Combinational sign / operation resolution on the incoming beat
  // ---------------------------------------------------------------------------
  logic              comp_eff;
  logic              sb_eff;
  logic              eff_sub_c;
  logic              zero_c;
  logic              s_c;
  logic [MANT_W-1:0] ma_c;
  logic [MANT_W-1:0] mb_c;
  logic [PW-1:0]     new_pay;

  always_comb begin
    // Equal magnitudes with comp=0 cannot happen upstream; force comp so the
    // stage stays deterministic if it does.
    comp_eff  = comp | mag_eq;
    // Subtraction is folded into B's sign.
    sb_eff    = s_b ^ a_s;
    eff_sub_c = s_a ^ sb_eff;
    zero_c    = eff_sub_c & mag_eq;
    // Larger-magnitude operand decides the sign.
    s_c       = comp_eff ? s_a : sb_eff;
    // Exact cancellation: IEEE-754 gives -0 only when rounding toward -inf.
    if (zero_c) begin
      s_c = (rm == RM_RDN);
    end
    if (SWAP_EN) begin
      ma_c = comp_eff ? ma_in : mb_in;
      mb_c = comp_eff ? mb_in : ma_in;
    end else begin
      ma_c = ma_in;
      mb_c = mb_in;
    end
    new_pay = {s_c, eff_sub_c, zero_c, ma_c, mb_c};
  end

  // ---------------------------------------------------------------------------
  // Main + skid storage
  // ---------------------------------------------------------------------------
  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_pay_q,   main_pay_d;
  logic [PW-1:0] skid_pay_q,   skid_pay_d;
  logic          fire_in;
  logic          fire_out;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign fire_in   = in_valid & in_ready;
  assign fire_out  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_pay_d   = main_pay_q;
    skid_pay_d   = skid_pay_q;
    if (flush) begin
      // Flush wins over any accept this cycle; the incoming beat is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (fire_out && skid_valid_q) begin
      // Skid drains into main. fire_in cannot occur here since in_ready=0.
      main_pay_d   = skid_pay_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (fire_in && (!main_valid_q || fire_out)) begin
      main_pay_d   = new_pay;
      main_valid_d = 1'b1;
    end else if (fire_in) begin
      // Main is stalled: park the beat; in_ready drops next cycle.
      skid_pay_d   = new_pay;
      skid_valid_d = 1'b1;
    end else if (fire_out) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pay_q   <= '0;
      skid_pay_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_pay_q   <= main_pay_d;
      skid_pay_q   <= skid_pay_d;
    end
  end

  assign s_o      = main_pay_q[PW-1];
  assign eff_sub  = main_pay_q[PW-2];
  assign zero_res = main_pay_q[PW-3];
  assign ma_o     = main_pay_q[2*MANT_W-1:MANT_W];
  assign mb_o     = main_pay_q[MANT_W-1:0];

endmodule

// File: tb/tb_fp_addsub_sign_stage.sv
// Bench for fp_addsub_sign_stage: directed vector table, reset/backpressure/flush
// sequences, and a random valid/ready stream against a reference model.
module tb_fp_addsub_sign_stage;

  localparam int W = 28;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         s_a, s_b, comp, mag_eq, a_s;
  logic [W-1:0] ma_in, mb_in;
  logic [2:0]   rm;
  logic         out_ready;

  logic         in_ready, out_valid, s_o, eff_sub, zero_res;
  logic [W-1:0] ma_o, mb_o;
  logic         in_ready_ns, out_valid_ns, s_o_ns, eff_sub_ns, zero_res_ns;
  logic [W-1:0] ma_o_ns, mb_o_ns;

  always #5 clk = ~clk;

  fp_addsub_sign_stage #(.MANT_W(W), .SWAP_EN(1'b1), .RM_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .s_a(s_a), .s_b(s_b), .ma_in(ma_in), .mb_in(mb_in), .comp(comp), .mag_eq(mag_eq),
    .a_s(a_s), .rm(rm), .out_valid(out_valid), .out_ready(out_ready), .s_o(s_o),
    .ma_o(ma_o), .mb_o(mb_o), .eff_sub(eff_sub), .zero_res(zero_res)
  );

  fp_addsub_sign_stage #(.MANT_W(W), .SWAP_EN(1'b0), .RM_W(3)) dut_ns (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_ns),
    .s_a(s_a), .s_b(s_b), .ma_in(ma_in), .mb_in(mb_in), .comp(comp), .mag_eq(mag_eq),
    .a_s(a_s), .rm(rm), .out_valid(out_valid_ns), .out_ready(out_ready), .s_o(s_o_ns),
    .ma_o(ma_o_ns), .mb_o(mb_o_ns), .eff_sub(eff_sub_ns), .zero_res(zero_res_ns)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic s_a, s_b, a_s, comp, mag_eq;
    logic [2:0]   rm;
    logic [W-1:0] ma, mb;
    logic e_s, e_sub, e_zero;
    logic [W-1:0] e_ma, e_mb;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic sa, input logic sb, input logic as_, input logic cp,
                         input logic me, input logic [2:0] r, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic es, input logic esub,
                         input logic ez, input logic [W-1:0] ea, input logic [W-1:0] eb);
    vec_t v;
    v.s_a = sa; v.s_b = sb; v.a_s = as_; v.comp = cp; v.mag_eq = me; v.rm = r;
    v.ma = a; v.mb = b; v.e_s = es; v.e_sub = esub; v.e_zero = ez; v.e_ma = ea; v.e_mb = eb;
    vq.push_back(v);
  endtask

  task automatic drive(input logic sa, input logic sb, input logic as_, input logic cp,
                       input logic me, input logic [2:0] r, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    s_a = sa; s_b = sb; a_s = as_; comp = cp; mag_eq = me; rm = r; ma_in = a; mb_in = b;
  endtask

  // Reference model: {s_o, eff_sub, zero_res, ma_o, mb_o} for SWAP_EN=1
  function automatic logic [63:0] ref_model(input logic sa, input logic sb, input logic as_,
                                            input logic cp, input logic me, input logic [2:0] r,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    logic bneg, sub, z, sgn, a_big;
    bneg  = as_ ? ~sb : sb;
    sub   = (sa != bneg);
    z     = sub && me;
    a_big = cp || me;
    if (z) sgn = (r == 3'd2);
    else   sgn = a_big ? sa : bneg;
    if (a_big) return {5'd0, sgn, sub, z, a, b};
    else       return {5'd0, sgn, sub, z, b, a};
  endfunction

  initial begin
    int sent;
    int cyc;
    logic holding;
    logic [63:0] exp_q[$];
    logic [63:0] ns_q[$];
    logic [63:0] e;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 28'h0000AAA, 28'h0000BBB);

    // ---------------- reset ----------------
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_payload", {ma_o, mb_o, s_o, eff_sub, zero_res}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("first_accept_valid", 64'(out_valid), 64'd1);
    check("first_accept_ma", 64'(ma_o), 64'h0000AAA);
    check("first_accept_s", 64'(s_o), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("first_drain_valid", 64'(out_valid), 64'd0);

    // ---------------- directed vector table ----------------
    add_vec(0,1,1,0,0,3'd0, 28'h0100000, 28'h0200000, 0,0,0, 28'h0200000, 28'h0100000);
    add_vec(0,0,1,1,1,3'd0, 28'h0ABCDEF, 28'h0ABCDEF, 0,1,1, 28'h0ABCDEF, 28'h0ABCDEF);
    add_vec(0,0,1,1,1,3'd2, 28'h0ABCDEF, 28'h0ABCDEF, 1,1,1, 28'h0ABCDEF, 28'h0ABCDEF);
    add_vec(1,1,1,1,1,3'd1, 28'h0ABCDEF, 28'h0ABCDEF, 0,1,1, 28'h0ABCDEF, 28'h0ABCDEF);
    add_vec(0,1,0,1,1,3'd3, 28'h0000400, 28'h0000400, 0,1,1, 28'h0000400, 28'h0000400);
    add_vec(1,1,0,0,1,3'd0, 28'h1234567, 28'h7654321, 1,0,0, 28'h1234567, 28'h7654321);
    add_vec(0,0,1,0,0,3'd0, 28'h0000010, 28'hFFFFFFF, 1,1,0, 28'hFFFFFFF, 28'h0000010);
    add_vec(1,0,0,1,0,3'd0, 28'h8000001, 28'h0000001, 1,1,0, 28'h8000001, 28'h0000001);
    add_vec(1,1,0,1,1,3'd2, 28'h0333333, 28'h0333333, 1,0,0, 28'h0333333, 28'h0333333);
    add_vec(1,0,0,1,1,3'd4, 28'h0555555, 28'h0555555, 0,1,1, 28'h0555555, 28'h0555555);
    add_vec(0,0,0,0,0,3'd2, 28'h0000001, 28'h0000002, 0,0,0, 28'h0000002, 28'h0000001);
    add_vec(1,1,1,0,0,3'd0, 28'h0000003, 28'h0000005, 0,1,0, 28'h0000005, 28'h0000003);

    foreach (vq[i]) begin
      drive(vq[i].s_a, vq[i].s_b, vq[i].a_s, vq[i].comp, vq[i].mag_eq, vq[i].rm, vq[i].ma, vq[i].mb);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_s_o", i), 64'(s_o), 64'(vq[i].e_s));
      check($sformatf("v%0d_eff_sub", i), 64'(eff_sub), 64'(vq[i].e_sub));
      check($sformatf("v%0d_zero_res", i), 64'(zero_res), 64'(vq[i].e_zero));
      check($sformatf("v%0d_ma_o", i), 64'(ma_o), 64'(vq[i].e_ma));
      check($sformatf("v%0d_mb_o", i), 64'(mb_o), 64'(vq[i].e_mb));
      check($sformatf("v%0d_ns_ma_o", i), 64'(ma_o_ns), 64'(vq[i].ma));
      check($sformatf("v%0d_ns_mb_o", i), 64'(mb_o_ns), 64'(vq[i].mb));
    end
    tick();
    check("table_drain_valid", 64'(out_valid), 64'd0);

    // ---------------- backpressure: beats 1..4 ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(0,0,0,1,0,3'd0, 28'd1, 28'd101);
    tick();
    check("bp_c1_in_ready", 64'(in_ready), 64'd1);
    check("bp_c1_ma", 64'(ma_o), 64'd1);
    drive(0,0,0,1,0,3'd0, 28'd2, 28'd102);
    tick();
    check("bp_c2_in_ready", 64'(in_ready), 64'd0);
    check("bp_c2_ma_stable", 64'(ma_o), 64'd1);
    drive(0,0,0,1,0,3'd0, 28'd3, 28'd103);
    tick();
    check("bp_c3_in_ready", 64'(in_ready), 64'd0);
    check("bp_c3_payload_stable", {ma_o, mb_o}, {28'd1, 28'd101});
    check("bp_c3_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_out2", {ma_o, mb_o}, {28'd2, 28'd102});
    check("bp_skid_freed", 64'(in_ready), 64'd1);
    tick();
    check("bp_out3", {ma_o, mb_o}, {28'd3, 28'd103});
    drive(0,0,0,1,0,3'd0, 28'd4, 28'd104);
    tick();
    check("bp_out4", {ma_o, mb_o}, {28'd4, 28'd104});
    in_valid = 1'b0;
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // ---------------- flush with main+skid full ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(0,0,0,1,0,3'd0, 28'd5, 28'd105);
    tick();
    drive(0,0,0,1,0,3'd0, 28'd6, 28'd106);
    tick();
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    drive(0,0,0,1,0,3'd0, 28'd7, 28'd107);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("fl_no_output_1", 64'(out_valid), 64'd0);
    tick();
    check("fl_no_output_2", 64'(out_valid), 64'd0);

    // flush vs simultaneous accept into an empty stage
    in_valid = 1'b1; flush = 1'b1;
    drive(0,0,0,1,0,3'd0, 28'd8, 28'd108);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_accept_dropped", 64'(out_valid), 64'd0);

    // ---------------- random stream vs model ----------------
    sent = 0; cyc = 0; holding = 1'b0;
    while ((sent < 10000 || holding || exp_q.size() > 0) && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_beat", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_payload", {5'd0, s_o, eff_sub, zero_res, ma_o, mb_o}, e);
          e = ns_q.pop_front();
          check("rnd_ns_payload", {8'd0, ma_o_ns, mb_o_ns}, e);
        end
      end
      if (!holding && sent < 10000 && $urandom_range(0, 3) != 0) begin
        s_a = 1'($urandom); s_b = 1'($urandom); a_s = 1'($urandom);
        comp = 1'($urandom); rm = 3'($urandom_range(0, 4));
        mag_eq = ($urandom_range(0, 3) == 0);
        ma_in = W'($urandom);
        mb_in = mag_eq ? ma_in : W'($urandom);
        holding = 1'b1;
      end
      in_valid = holding;
      if (holding && in_ready) begin
        exp_q.push_back(ref_model(s_a, s_b, a_s, comp, mag_eq, rm, ma_in, mb_in));
        ns_q.push_back({8'd0, ma_in, mb_in});
        sent++;
        holding = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_no_timeout", 64'(cyc < 60000), 64'd1);
    check("rnd_all_sent", 64'(sent), 64'd10000);
    check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
